// File: rtl/mccpu_ctrl_pkg.sv
// Shared encodings for the handshaking multicycle MIPS controller.
// States, ALU ops, mux selects, trap causes, opcodes and funct codes.
package mccpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXE  = 4'd2,
    S_EXW  = 4'd3,
    S_MEM  = 4'd4,
    S_WB   = 4'd5,
    S_TRAP = 4'd6
  } state_e;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_NOR  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_SLLV = 4'd11;
  localparam logic [3:0] ALU_SRLV = 4'd12;

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_31 = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;
  localparam logic [1:0] WD_MD  = 2'd3;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_EXC = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_MEM  = 2'd2;
  localparam logic [1:0] CAUSE_MD   = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_SLTIU = 6'd11;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_SLLV  = 6'd4;
  localparam logic [5:0] FN_SRLV  = 6'd6;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_JALR  = 6'd9;
  localparam logic [5:0] FN_MULT  = 6'd24;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIV   = 6'd26;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_ADDU  = 6'd33;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SUBU  = 6'd35;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_NOR   = 6'd39;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLTU  = 6'd43;

  typedef struct packed {
    logic       j;
    logic       jal;
    logic       beq;
    logic       bne;
    logic       lw;
    logic       sw;
    logic       shamt;
    logic       itype;
    logic       zext;
    logic       md;
    logic       jr;
    logic       jalr;
    logic       illegal;
    logic [3:0] aluop;
  } dec_t;

endpackage

// File: rtl/mccpu_decode.sv
// Instruction classifier: class flags, ALU op and illegal flag.
// Purely combinational from the IR opcode and funct fields.
module mccpu_decode
  import mccpu_ctrl_pkg::*;
#(
  parameter int ENABLE_MULDIV = 1
) (
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.aluop = ALU_ADD;
    unique case (op_i)
      OP_RTYPE: begin
        unique case (funct_i)
          FN_ADD, FN_ADDU: dec_o.aluop = ALU_ADD;
          FN_SUB, FN_SUBU: dec_o.aluop = ALU_SUB;
          FN_AND:  dec_o.aluop = ALU_AND;
          FN_OR:   dec_o.aluop = ALU_OR;
          FN_NOR:  dec_o.aluop = ALU_NOR;
          FN_SLT:  dec_o.aluop = ALU_SLT;
          FN_SLTU: dec_o.aluop = ALU_SLTU;
          FN_SLLV: dec_o.aluop = ALU_SLLV;
          FN_SRLV: dec_o.aluop = ALU_SRLV;
          FN_SLL: begin
            dec_o.shamt = 1'b1;
            dec_o.aluop = ALU_SLL;
          end
          FN_SRL: begin
            dec_o.shamt = 1'b1;
            dec_o.aluop = ALU_SRL;
          end
          FN_JR:   dec_o.jr = 1'b1;
          FN_JALR: dec_o.jalr = 1'b1;
          FN_MULT, FN_MULTU,
          FN_DIV, FN_DIVU: begin
            dec_o.md      = (ENABLE_MULDIV != 0);
            dec_o.illegal = (ENABLE_MULDIV == 0);
            dec_o.aluop   = ALU_NOP;
          end
          default: dec_o.illegal = 1'b1;
        endcase
      end
      OP_J:   dec_o.j = 1'b1;
      OP_JAL: dec_o.jal = 1'b1;
      OP_BEQ: begin
        dec_o.beq   = 1'b1;
        dec_o.aluop = ALU_SUB;
      end
      OP_BNE: begin
        dec_o.bne   = 1'b1;
        dec_o.aluop = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: dec_o.itype = 1'b1;
      OP_SLTI: begin
        dec_o.itype = 1'b1;
        dec_o.aluop = ALU_SLT;
      end
      OP_SLTIU: begin
        dec_o.itype = 1'b1;
        dec_o.aluop = ALU_SLTU;
      end
      OP_ANDI: begin
        dec_o.itype = 1'b1;
        dec_o.zext  = 1'b1;
        dec_o.aluop = ALU_AND;
      end
      OP_ORI: begin
        dec_o.itype = 1'b1;
        dec_o.zext  = 1'b1;
        dec_o.aluop = ALU_OR;
      end
      OP_LUI: begin
        dec_o.itype = 1'b1;
        dec_o.aluop = ALU_LUI;
      end
      OP_LW: dec_o.lw = 1'b1;
      OP_SW: dec_o.sw = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mccpu_ctrl_hs.sv
// Multicycle MIPS control FSM with memory/muldiv ready handshakes,
// a wait-cycle watchdog and a trap path for illegal ops and timeouts.
module mccpu_ctrl_hs
  import mccpu_ctrl_pkg::*;
#(
  parameter int ALUOP_W       = 4,
  parameter int ENABLE_MULDIV = 1,
  parameter int TIMEOUT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Zero,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               mem_ready,
  input  logic               md_done,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               EXTOp,
  output logic               IorD,
  output logic               md_start,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [3:0]         state_o
);

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0]           cause_q, cause_d;
  logic                 tmo;
  logic [3:0]           aluop;
  logic                 rw, mw, mr, pw, iw, ms, tp;
  dec_t                 dec;

  mccpu_decode #(
    .ENABLE_MULDIV(ENABLE_MULDIV)
  ) u_decode (
    .op_i   (Op),
    .funct_i(Funct),
    .dec_o  (dec)
  );

  // Timeout is taken on the wait cycle that would make the counter all-ones.
  assign cnt_inc = cnt_q + TIMEOUT_W'(1);
  assign tmo     = &cnt_inc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cause_d  = cause_q;
    rw       = 1'b0;
    mw       = 1'b0;
    mr       = 1'b0;
    pw       = 1'b0;
    iw       = 1'b0;
    ms       = 1'b0;
    tp       = 1'b0;
    EXTOp    = 1'b1;
    ALUSrcA  = 2'd1;
    ALUSrcB  = 2'd0;
    aluop    = ALU_ADD;
    GPRSel   = GPR_RD;
    WDSel    = WD_ALU;
    PCSource = PC_SEQ;
    IorD     = 1'b0;
    unique case (state_q)
      S_IF: begin
        mr      = 1'b1;
        ALUSrcA = 2'd0;
        ALUSrcB = 2'd1;
        if (mem_ready) begin
          pw      = 1'b1;
          iw      = 1'b1;
          state_d = S_ID;
        end else if (tmo) begin
          mr      = 1'b0;
          cause_d = CAUSE_MEM;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ID: begin
        if (dec.illegal) begin
          cause_d = CAUSE_ILL;
          state_d = S_TRAP;
        end else if (dec.j || dec.jal) begin
          PCSource = PC_JMP;
          pw       = 1'b1;
          state_d  = S_IF;
          if (dec.jal) begin
            rw     = 1'b1;
            GPRSel = GPR_31;
            WDSel  = WD_PC;
          end
        end else begin
          ALUSrcA = 2'd0;
          ALUSrcB = 2'd3;
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        aluop = dec.aluop;
        unique case (1'b1)
          dec.beq, dec.bne: begin
            PCSource = PC_BR;
            pw       = (dec.beq & Zero) | (dec.bne & ~Zero);
            state_d  = S_IF;
          end
          dec.lw, dec.sw: begin
            ALUSrcB = 2'd2;
            state_d = S_MEM;
          end
          dec.shamt: begin
            ALUSrcA = 2'd2;
            state_d = S_WB;
          end
          dec.itype: begin
            ALUSrcB = 2'd2;
            EXTOp   = ~dec.zext;
            state_d = S_WB;
          end
          dec.md: begin
            ms      = 1'b1;
            state_d = S_EXW;
          end
          dec.jr, dec.jalr: begin
            aluop   = ALU_ADD;
            pw      = 1'b1;
            state_d = S_IF;
            if (dec.jalr) begin
              rw    = 1'b1;
              WDSel = WD_PC;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_EXW: begin
        if (md_done) begin
          state_d = S_WB;
        end else if (tmo) begin
          cause_d = CAUSE_MD;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEM: begin
        IorD = 1'b1;
        mr   = dec.lw;
        mw   = dec.sw;
        if (mem_ready) begin
          state_d = dec.lw ? S_WB : S_IF;
        end else if (tmo) begin
          mr      = 1'b0;
          mw      = 1'b0;
          cause_d = CAUSE_MEM;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        state_d = S_IF;
        if (dec.lw) begin
          WDSel  = WD_MEM;
          GPRSel = GPR_RT;
        end else if (dec.itype) begin
          GPRSel = GPR_RT;
        end else if (dec.md) begin
          WDSel = WD_MD;
        end
      end
      S_TRAP: begin
        tp       = 1'b1;
        pw       = 1'b1;
        PCSource = PC_EXC;
        state_d  = S_IF;
      end
      default: state_d = S_IF;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  assign RegWrite   = rw & ~rst;
  assign MemWrite   = mw & ~rst;
  assign MemRead    = mr & ~rst;
  assign PCWrite    = pw & ~rst;
  assign IRWrite    = iw & ~rst;
  assign md_start   = ms & ~rst;
  assign trap       = tp & ~rst;
  assign ALUOp      = ALUOP_W'(aluop);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mccpu_ctrl_hs.sv
// Scoreboard bench for mccpu_ctrl_hs: per-cycle expected control words
// are queued by the stimulus and compared by an independent monitor.
module tb_mccpu_ctrl_hs;

  typedef struct packed {
    logic [3:0] st;
    logic       rw, mw, mr, pw, iw, ms, tp, iord, ext;
    logic [1:0] asa, asb, pcs, gpr, wds;
    logic [3:0] alu;
    logic [1:0] cause;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       md_done = 1'b0;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd32;

  logic       a_rw, a_mw, a_mr, a_pw, a_iw, a_ext, a_iord, a_ms, a_tp;
  logic [1:0] a_asa, a_asb, a_pcs, a_gpr, a_wds, a_cause;
  logic [3:0] a_alu, a_st;
  logic       b_rw, b_mw, b_mr, b_pw, b_iw, b_ext, b_iord, b_ms, b_tp;
  logic [1:0] b_asa, b_asb, b_pcs, b_gpr, b_wds, b_cause;
  logic [3:0] b_alu, b_st;

  mccpu_ctrl_hs #(
    .ALUOP_W(4), .ENABLE_MULDIV(1), .TIMEOUT_W(3)
  ) u_dut (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
    .mem_ready(mem_ready), .md_done(md_done),
    .RegWrite(a_rw), .MemWrite(a_mw), .MemRead(a_mr),
    .PCWrite(a_pw), .IRWrite(a_iw), .EXTOp(a_ext), .IorD(a_iord),
    .md_start(a_ms), .ALUSrcA(a_asa), .ALUSrcB(a_asb),
    .PCSource(a_pcs), .GPRSel(a_gpr), .WDSel(a_wds), .ALUOp(a_alu),
    .trap(a_tp), .trap_cause(a_cause), .state_o(a_st)
  );

  mccpu_ctrl_hs #(
    .ALUOP_W(4), .ENABLE_MULDIV(0), .TIMEOUT_W(3)
  ) u_nomd (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct),
    .mem_ready(mem_ready), .md_done(md_done),
    .RegWrite(b_rw), .MemWrite(b_mw), .MemRead(b_mr),
    .PCWrite(b_pw), .IRWrite(b_iw), .EXTOp(b_ext), .IorD(b_iord),
    .md_start(b_ms), .ALUSrcA(b_asa), .ALUSrcB(b_asb),
    .PCSource(b_pcs), .GPRSel(b_gpr), .WDSel(b_wds), .ALUOp(b_alu),
    .trap(b_tp), .trap_cause(b_cause), .state_o(b_st)
  );

  obs_t oa, ob;
  assign oa = {a_st, a_rw, a_mw, a_mr, a_pw, a_iw, a_ms, a_tp, a_iord,
               a_ext, a_asa, a_asb, a_pcs, a_gpr, a_wds, a_alu, a_cause};
  assign ob = {b_st, b_rw, b_mw, b_mr, b_pw, b_iw, b_ms, b_tp, b_iord,
               b_ext, b_asa, b_asb, b_pcs, b_gpr, b_wds, b_alu, b_cause};

  always #5 clk = ~clk;

  obs_t  eq[$];
  bit    sq[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  obs_t  m_e, m_g;
  bit    m_s;
  string m_n;

  always @(negedge clk) begin
    if (eq.size() != 0) begin
      m_e = eq.pop_front();
      m_s = sq.pop_front();
      m_n = nq.pop_front();
      m_g = m_s ? ob : oa;
      checks++;
      if (m_g !== m_e) begin
        errors++;
        $display("FAIL %s: got %h required %h", m_n, m_g, m_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit, required end of stimulus");
    $fatal(1);
  end

  function automatic obs_t ex(input logic [3:0] st, input logic [1:0] c);
    obs_t e;
    e       = '0;
    e.st    = st;
    e.ext   = 1'b1;
    e.asa   = 2'd1;
    e.alu   = 4'd1;
    e.cause = c;
    return e;
  endfunction

  function automatic obs_t fetch(input logic rdy, input logic [1:0] c);
    obs_t e;
    e     = ex(4'd0, c);
    e.mr  = 1'b1;
    e.asa = 2'd0;
    e.asb = 2'd1;
    e.pw  = rdy;
    e.iw  = rdy;
    return e;
  endfunction

  function automatic obs_t dec_ok();
    obs_t e;
    e     = ex(4'd1, 2'd0);
    e.asa = 2'd0;
    e.asb = 2'd3;
    return e;
  endfunction

  task automatic cyc(input string n, input obs_t e, input bit s = 1'b0);
    eq.push_back(e);
    sq.push_back(s);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_ready = 1'b1;
    md_done   = 1'b0;
    Zero      = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fd(input string p);
    cyc({p, "_if"}, fetch(1'b1, 2'd0));
    cyc({p, "_id"}, dec_ok());
  endtask

  initial begin
    obs_t e;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    e    = fetch(1'b0, 2'd0);
    e.mr = 1'b0;
    cyc("rst_a", e);
    cyc("rst_b", e, 1'b1);
    rst = 1'b0;

    // add
    Op = 6'd0; Funct = 6'd32;
    fd("add");
    cyc("add_exe", ex(4'd2, 2'd0));
    e = ex(4'd5, 2'd0); e.rw = 1'b1;
    cyc("add_wb", e);
    cyc("add_if2", fetch(1'b1, 2'd0));
    do_reset();

    // lw with three not-ready cycles
    Op = 6'd35;
    fd("lw");
    e = ex(4'd2, 2'd0); e.asb = 2'd2;
    cyc("lw_exe", e);
    mem_ready = 1'b0;
    e = ex(4'd4, 2'd0); e.iord = 1'b1; e.mr = 1'b1;
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", e);
    mem_ready = 1'b1;
    cyc("lw_mem_rdy", e);
    e = ex(4'd5, 2'd0); e.rw = 1'b1; e.wds = 2'd1; e.gpr = 2'd1;
    cyc("lw_wb", e);
    cyc("lw_if", fetch(1'b1, 2'd0));
    do_reset();

    // fetch waits two cycles
    Op = 6'd0; Funct = 6'd32; mem_ready = 1'b0;
    cyc("ifw_wait0", fetch(1'b0, 2'd0));
    cyc("ifw_wait1", fetch(1'b0, 2'd0));
    mem_ready = 1'b1;
    cyc("ifw_rdy", fetch(1'b1, 2'd0));
    cyc("ifw_id", dec_ok());
    do_reset();

    // illegal opcode
    Op = 6'b111111;
    cyc("ill_if", fetch(1'b1, 2'd0));
    cyc("ill_id", ex(4'd1, 2'd0));
    e = ex(4'd6, 2'd1); e.tp = 1'b1; e.pcs = 2'd3; e.pw = 1'b1;
    cyc("ill_trap", e);
    cyc("ill_if2", fetch(1'b1, 2'd1));
    do_reset();

    // sw timeout after 7 wait cycles
    Op = 6'd43;
    fd("swt");
    e = ex(4'd2, 2'd0); e.asb = 2'd2;
    cyc("swt_exe", e);
    mem_ready = 1'b0;
    e = ex(4'd4, 2'd0); e.iord = 1'b1; e.mw = 1'b1;
    for (int i = 0; i < 6; i++) cyc("swt_wait", e);
    e.mw = 1'b0;
    cyc("swt_tmo", e);
    mem_ready = 1'b1;
    e = ex(4'd6, 2'd2); e.tp = 1'b1; e.pcs = 2'd3; e.pw = 1'b1;
    cyc("swt_trap", e);
    cyc("swt_if", fetch(1'b1, 2'd2));
    do_reset();

    // ready on the would-be timeout cycle wins
    Op = 6'd43;
    fd("swr");
    e = ex(4'd2, 2'd0); e.asb = 2'd2;
    cyc("swr_exe", e);
    mem_ready = 1'b0;
    e = ex(4'd4, 2'd0); e.iord = 1'b1; e.mw = 1'b1;
    for (int i = 0; i < 6; i++) cyc("swr_wait", e);
    mem_ready = 1'b1;
    cyc("swr_rdy", e);
    cyc("swr_if", fetch(1'b1, 2'd0));
    do_reset();

    // reset during a memory wait
    Op = 6'd35;
    fd("lwr");
    e = ex(4'd2, 2'd0); e.asb = 2'd2;
    cyc("lwr_exe", e);
    mem_ready = 1'b0;
    e = ex(4'd4, 2'd0); e.iord = 1'b1; e.mr = 1'b1;
    cyc("lwr_wait", e);
    rst = 1'b1;
    e.mr = 1'b0;
    cyc("lwr_rst", e);
    rst = 1'b0; mem_ready = 1'b1;
    cyc("lwr_if", fetch(1'b1, 2'd0));
    do_reset();

    // mult, done on the fifth EXW cycle
    Op = 6'd0; Funct = 6'd24;
    fd("mul");
    e = ex(4'd2, 2'd0); e.ms = 1'b1; e.alu = 4'd0;
    cyc("mul_exe", e);
    for (int i = 0; i < 4; i++) cyc("mul_exw", ex(4'd3, 2'd0));
    md_done = 1'b1;
    cyc("mul_done", ex(4'd3, 2'd0));
    md_done = 1'b0;
    e = ex(4'd5, 2'd0); e.rw = 1'b1; e.wds = 2'd3;
    cyc("mul_wb", e);
    cyc("mul_if", fetch(1'b1, 2'd0));
    do_reset();

    // mult without the muldiv unit
    cyc("nmd_if", fetch(1'b1, 2'd0), 1'b1);
    cyc("nmd_id", ex(4'd1, 2'd0), 1'b1);
    e = ex(4'd6, 2'd1); e.tp = 1'b1; e.pcs = 2'd3; e.pw = 1'b1;
    cyc("nmd_trap", e, 1'b1);
    cyc("nmd_if2", fetch(1'b1, 2'd1), 1'b1);
    do_reset();

    // beq taken, bne not taken
    Op = 6'd4; Zero = 1'b1;
    fd("beq");
    e = ex(4'd2, 2'd0); e.alu = 4'd2; e.pcs = 2'd1; e.pw = 1'b1;
    cyc("beq_exe", e);
    cyc("beq_if", fetch(1'b1, 2'd0));
    do_reset();
    Op = 6'd5; Zero = 1'b1;
    fd("bne");
    e = ex(4'd2, 2'd0); e.alu = 4'd2; e.pcs = 2'd1;
    cyc("bne_exe", e);
    cyc("bne_if", fetch(1'b1, 2'd0));
    do_reset();

    // j and jal
    Op = 6'd2;
    cyc("j_if", fetch(1'b1, 2'd0));
    e = ex(4'd1, 2'd0); e.pcs = 2'd2; e.pw = 1'b1;
    cyc("j_id", e);
    cyc("j_if2", fetch(1'b1, 2'd0));
    do_reset();
    Op = 6'd3;
    cyc("jal_if", fetch(1'b1, 2'd0));
    e = ex(4'd1, 2'd0); e.pcs = 2'd2; e.pw = 1'b1;
    e.rw = 1'b1; e.gpr = 2'd2; e.wds = 2'd2;
    cyc("jal_id", e);
    do_reset();

    // ori zero-extends and writes rt
    Op = 6'd13;
    fd("ori");
    e = ex(4'd2, 2'd0); e.asb = 2'd2; e.ext = 1'b0; e.alu = 4'd4;
    cyc("ori_exe", e);
    e = ex(4'd5, 2'd0); e.rw = 1'b1; e.gpr = 2'd1;
    cyc("ori_wb", e);
    do_reset();

    // sll uses shamt on port A
    Op = 6'd0; Funct = 6'd0;
    fd("sll");
    e = ex(4'd2, 2'd0); e.asa = 2'd2; e.alu = 4'd7;
    cyc("sll_exe", e);
    e = ex(4'd5, 2'd0); e.rw = 1'b1;
    cyc("sll_wb", e);
    do_reset();

    // jalr
    Op = 6'd0; Funct = 6'd9;
    fd("jalr");
    e = ex(4'd2, 2'd0); e.pw = 1'b1; e.rw = 1'b1; e.wds = 2'd2;
    cyc("jalr_exe", e);
    cyc("jalr_if", fetch(1'b1, 2'd0));

    @(negedge clk);
    #1;
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d queued required 0", eq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mccpu_ctrl_hs.md
Name: mccpu_ctrl_hs

Overview:
- Next-generation multicycle MIPS control FSM.
- Adds a ready-handshake for variable-latency memory (instruction and data), a wait state for an optional iterative mult/div unit, a wait-timeout watchdog, and a trap path for illegal opcodes and timeouts.
- Drives the same datapath muxes as the current controller: PC, IR, regfile, ALU, memory address mux.

Parameters:
- ALUOP_W, 4, width of ALUOp; encodings come from the shared package and are zero-padded to this width.
- ENABLE_MULDIV, 1, when 1 mult/div funct codes are legal; when 0 they trap as illegal.
- TIMEOUT_W, 8, width of the wait-cycle counter; timeout fires after 2**TIMEOUT_W-1 consecutive wait cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- Zero  in  1  ALU zero flag
- Op  in  6  instruction opcode (from IR)
- Funct  in  6  instruction funct (from IR)
- mem_ready  in  1  memory completes the current read/write this cycle
- md_done  in  1  mult/div unit result valid
- RegWrite, MemWrite, MemRead, PCWrite, IRWrite, EXTOp, IorD  out  1  datapath strobes/selects
- md_start  out  1  one-cycle start pulse to the mult/div unit
- ALUSrcA, ALUSrcB, PCSource, GPRSel, WDSel  out  2  mux selects; PCSource 3 = exception vector, WDSel 3 = mult/div result
- ALUOp  out  ALUOP_W  ALU operation
- trap  out  1  one-cycle pulse on entry to TRAP
- trap_cause  out  2  registered cause: 0 none, 1 illegal, 2 mem timeout, 3 muldiv timeout
- state_o  out  4  current state, for debug

Behaviour:
- State register and wait counter are updated on posedge clk. rst=1 forces state IF, counter 0, trap_cause 0.
- All outputs are combinational from the current state. While rst=1 every strobe (RegWrite, MemWrite, MemRead, PCWrite, IRWrite, md_start, trap) is forced 0.
- Defaults in every state: strobes 0, EXTOp=1, ALUSrcA=1, ALUSrcB=0, ALUOp=ADD, GPRSel=RD, WDSel=ALU, PCSource=0, IorD=0.
- States: IF, ID, EXE, EXW, MEM, WB, TRAP.
- IF:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1.
  - mem_ready=1: PCWrite=IRWrite=1 in that same cycle only, then go to ID.
  - Otherwise stay in IF, counter++.
- ID:
  - j: PCSource=2, PCWrite, go to IF.
  - jal: additionally RegWrite, GPRSel=31, WDSel=PC.
  - Illegal opcode/funct: go to TRAP, cause 1.
  - Otherwise: ALUSrcA=0, ALUSrcB=3 (branch target computed), go to EXE.
- EXE:
  - ALUOp decoded per instruction, encodings identical to the current controller.
  - beq/bne: PCSource=1, PCWrite=(beq&Zero)|(bne&~Zero), go to IF.
  - lw/sw: ALUSrcB=2, go to MEM.
  - sll/srl: ALUSrcA=2, go to WB.
  - I-type ALU: ALUSrcB=2; ori/andi use EXTOp=0.
  - mult/div: md_start=1, go to EXW.
  - jr: PCSource=0 with ALUSrcA=1, ALUSrcB=0, ALUOp=ADD of rs+zero, PCWrite, go to IF.
  - jalr: as jr, plus RegWrite, WDSel=PC, GPRSel=RD.
- EXW: wait for md_done, then go to WB with WDSel=3. Each waiting cycle counter++.
- MEM:
  - IorD=1; lw drives MemRead=1, sw drives MemWrite=1. The strobe is held every cycle until mem_ready.
  - On mem_ready: lw goes to WB, sw goes to IF.
- WB:
  - RegWrite=1 for exactly one cycle, then go to IF.
  - lw uses WDSel=MEM; I-type uses GPRSel=RT.
- Watchdog:
  - Counter clears on every state change.
  - Counter reaching all-ones while still waiting (IF/MEM without ready, EXW without done) goes to TRAP, cause 2 or 3. No write strobe is issued on the timeout cycle.
- TRAP: trap=1, PCSource=3, PCWrite=1 for one cycle, then IF. trap_cause holds until the next trap or reset.
- Simultaneous ready and timeout in the same cycle: ready wins.
- Reset mid-wait abandons the access; no strobe on the reset cycle.

Decomposition:
- Package mccpu_ctrl_pkg holds:
  - state encodings;
  - ALUOp constants (NOP, ADD, SUB, AND, OR, SLT, SLTU, SLL, SRL, NOR, LUI, SLLV, SRLV);
  - GPRSel, WDSel and PCSource constants;
  - trap cause codes;
  - opcode/funct constants.
- One sub-module, mccpu_decode: combinational instruction-class flags plus ALUOp and an illegal flag. The FSM stays in the top.

Test Plan:
- add with mem_ready tied 1: states IF→ID→EXE→WB→IF in 4 cycles; RegWrite high exactly in WB; PCWrite exactly once.
- lw with mem_ready low 3 cycles in MEM: MemRead held for 4 cycles, IorD=1; WB has WDSel=1, GPRSel=1.
- IF with mem_ready low 2 cycles: PCWrite/IRWrite stay 0 until the ready cycle, then pulse once.
- Op=6'b111111: ID→TRAP; trap pulses, trap_cause=1, PCSource=3, PCWrite=1; next state IF.
- With TIMEOUT_W=3 and mem_ready held 0 in MEM for sw: TRAP after 7 wait cycles, cause 2; MemWrite never asserted on the trap cycle.
- mult with md_done after 5 cycles: md_start one-cycle pulse; EXW for 5 cycles; WB WDSel=3. With ENABLE_MULDIV=0 the same instruction traps with cause 1.
